// File: rtl/alu_pkg.sv
// Shared command encodings, FSM states and timing constants for the ALU core.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef CMD_WIDTH
`define CMD_WIDTH 4
`endif

package alu_pkg;

  typedef enum logic [3:0] {
    A_ADD     = 4'd0,
    A_SUB     = 4'd1,
    A_ADD_CIN = 4'd2,
    A_SUB_CIN = 4'd3,
    A_INC_A   = 4'd4,
    A_DEC_A   = 4'd5,
    A_INC_B   = 4'd6,
    A_DEC_B   = 4'd7,
    A_CMP     = 4'd8,
    A_MUL_INC = 4'd9,
    A_MUL_SHL = 4'd10
  } arith_cmd_e;

  typedef enum logic [3:0] {
    L_AND     = 4'd0,
    L_NAND    = 4'd1,
    L_OR      = 4'd2,
    L_NOR     = 4'd3,
    L_XOR     = 4'd4,
    L_XNOR    = 4'd5,
    L_NOT_A   = 4'd6,
    L_NOT_B   = 4'd7,
    L_SHR1_A  = 4'd8,
    L_SHL1_A  = 4'd9,
    L_SHR1_B  = 4'd10,
    L_SHL1_B  = 4'd11,
    L_ROL_A_B = 4'd12,
    L_ROR_A_B = 4'd13
  } logic_cmd_e;

  typedef enum logic [1:0] {IDLE, WAIT_OPER, EXEC, MUL_WAIT} state_e;

  localparam int unsigned TIMEOUT_CYCLES = 16;
  localparam int unsigned TMO_W          = $clog2(TIMEOUT_CYCLES);

  // Operand-valid bits a command needs: bit0 = opa, bit1 = opb.
  function automatic logic [1:0] req_mask(input logic mode, input logic [3:0] op,
                                          input logic hi);
    logic [1:0] m;
    m = 2'b11;
    if (!hi) begin
      if (mode) begin
        case (op)
          A_INC_A, A_DEC_A: m = 2'b01;
          A_INC_B, A_DEC_B: m = 2'b10;
          default:          m = 2'b11;
        endcase
      end else begin
        case (op)
          L_NOT_A, L_SHR1_A, L_SHL1_A: m = 2'b01;
          L_NOT_B, L_SHR1_B, L_SHL1_B: m = 2'b10;
          default:                     m = 2'b11;
        endcase
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/alu_mul_pipe.sv
// Two-stage registered multiplier: stage 1 forms the adjusted operands, stage 2 the product.
module alu_mul_pipe #(
  parameter int DATA_WIDTH   = 8,
  parameter int RESULT_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ce,
  input  logic                    shl,
  input  logic [DATA_WIDTH-1:0]   a,
  input  logic [DATA_WIDTH-1:0]   b,
  output logic [RESULT_WIDTH-1:0] p
);
  localparam int PW = 2*DATA_WIDTH + 2;

  logic [DATA_WIDTH:0] x, y;
  logic [PW-1:0]       prod;

  assign prod = PW'(x) * PW'(y);

  always_ff @(posedge clk) begin
    if (rst) begin
      x <= '0;
      y <= '0;
      p <= '0;
    end else if (ce) begin
      x <= shl ? {a, 1'b0} : (DATA_WIDTH+1)'(a) + (DATA_WIDTH+1)'(1);
      y <= shl ? {1'b0, b} : (DATA_WIDTH+1)'(b) + (DATA_WIDTH+1)'(1);
      p <= RESULT_WIDTH'(prod);
    end
  end
endmodule

// File: rtl/alu_core.sv
// Sequential ALU: collects operands (possibly over several cycles), executes, registers flags.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef CMD_WIDTH
`define CMD_WIDTH 4
`endif

module alu_core
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH   = `DATA_WIDTH,
  parameter int CMD_WIDTH    = `CMD_WIDTH,
  parameter int RESULT_WIDTH = 2*DATA_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ce,
  input  logic                    mode,
  input  logic                    cin,
  input  logic [CMD_WIDTH-1:0]    cmd,
  input  logic [1:0]              inp_valid,
  input  logic [DATA_WIDTH-1:0]   opa,
  input  logic [DATA_WIDTH-1:0]   opb,
  output logic [RESULT_WIDTH-1:0] res,
  output logic                    err,
  output logic                    oflow,
  output logic                    cout,
  output logic                    g,
  output logic                    l,
  output logic                    e
);
  localparam int SH = $clog2(DATA_WIDTH);

  state_e                  state, state_n;
  logic [DATA_WIDTH-1:0]   a_r, b_r;
  logic [CMD_WIDTH-1:0]    cmd_r;
  logic                    mode_r, cin_r;
  logic [1:0]              got_r, got_n, req_in, req_r;
  logic [TMO_W-1:0]        tcnt_r, tcnt_n;
  logic                    mcnt_r, mcnt_n;
  logic                    ld_a, ld_b, ld_ctl, fin_exec, fin_tmo, fin_mul;
  logic [3:0]              op_in, op_r;
  logic                    hi_in, hi_r, is_mul;
  logic [RESULT_WIDTH-1:0] mul_p, r_res;
  logic                    r_err, r_oflow, r_cout, r_g, r_l, r_e;
  logic [DATA_WIDTH:0]     a1, b1, one, cx, sum;
  logic [DATA_WIDTH-1:0]   lres;
  logic [2*DATA_WIDTH-1:0] rot;
  logic [SH-1:0]           amt;

  assign op_in  = 4'(cmd);
  assign op_r   = 4'(cmd_r);
  assign hi_in  = (cmd >> 4) != '0;
  assign hi_r   = (cmd_r >> 4) != '0;
  assign req_in = req_mask(mode, op_in, hi_in);
  assign req_r  = req_mask(mode_r, op_r, hi_r);
  assign is_mul = mode_r && !hi_r && (op_r == A_MUL_INC || op_r == A_MUL_SHL);
  assign a1     = {1'b0, a_r};
  assign b1     = {1'b0, b_r};
  assign one    = (DATA_WIDTH+1)'(1);
  assign amt    = b_r[SH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      got_r  <= '0;
      tcnt_r <= '0;
      mcnt_r <= 1'b0;
    end else if (ce) begin
      state  <= state_n;
      got_r  <= got_n;
      tcnt_r <= tcnt_n;
      mcnt_r <= mcnt_n;
    end
  end

  always_comb begin
    state_n  = state;
    got_n    = got_r;
    tcnt_n   = tcnt_r;
    mcnt_n   = mcnt_r;
    ld_a     = 1'b0;
    ld_b     = 1'b0;
    ld_ctl   = 1'b0;
    fin_exec = 1'b0;
    fin_tmo  = 1'b0;
    fin_mul  = 1'b0;
    case (state)
      IDLE: if (inp_valid != 2'b00) begin
        ld_ctl  = 1'b1;
        ld_a    = inp_valid[0];
        ld_b    = inp_valid[1];
        got_n   = inp_valid;
        tcnt_n  = '0;
        state_n = ((inp_valid & req_in) == req_in) ? EXEC : WAIT_OPER;
      end
      WAIT_OPER: begin
        // Only operands still missing are captured; repeats of a held one are ignored.
        ld_a  = inp_valid[0] & ~got_r[0];
        ld_b  = inp_valid[1] & ~got_r[1];
        got_n = got_r | inp_valid;
        if ((got_n & req_r) == req_r) state_n = EXEC;
        else if (tcnt_r == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          fin_tmo = 1'b1;
          state_n = IDLE;
        end else tcnt_n = tcnt_r + TMO_W'(1);
      end
      EXEC: if (is_mul) begin
        mcnt_n  = 1'b0;
        state_n = MUL_WAIT;
      end else begin
        fin_exec = 1'b1;
        state_n  = IDLE;
      end
      MUL_WAIT: if (mcnt_r) begin
        fin_mul = 1'b1;
        state_n = IDLE;
      end else mcnt_n = 1'b1;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_r    <= '0;
      b_r    <= '0;
      cmd_r  <= '0;
      mode_r <= 1'b0;
      cin_r  <= 1'b0;
    end else if (ce) begin
      if (ld_a) a_r <= opa;
      if (ld_b) b_r <= opb;
      if (ld_ctl) begin
        cmd_r  <= cmd;
        mode_r <= mode;
        cin_r  <= cin;
      end
    end
  end

  always_comb begin
    r_res = '0; r_err = 1'b0; r_oflow = 1'b0; r_cout = 1'b0;
    r_g = 1'b0; r_l = 1'b0; r_e = 1'b0;
    sum = '0; lres = '0; rot = '0;
    cx = (mode_r && (op_r == A_ADD_CIN || op_r == A_SUB_CIN)) ? (DATA_WIDTH+1)'(cin_r) : '0;
    if (hi_r) r_err = 1'b1;
    else if (mode_r) begin
      case (op_r)
        A_ADD, A_ADD_CIN: begin sum = a1 + b1 + cx; r_cout = sum[DATA_WIDTH]; end
        A_SUB, A_SUB_CIN: begin sum = a1 - b1 - cx; r_oflow = a1 < (b1 + cx); end
        A_INC_A:          sum = a1 + one;
        A_DEC_A:          sum = a1 - one;
        A_INC_B:          sum = b1 + one;
        A_DEC_B:          sum = b1 - one;
        A_CMP:            begin r_g = a_r > b_r; r_l = a_r < b_r; r_e = a_r == b_r; end
        A_MUL_INC, A_MUL_SHL: r_err = 1'b0;
        default:          r_err = 1'b1;
      endcase
      r_res = RESULT_WIDTH'(sum);
    end else begin
      case (op_r)
        L_AND:     lres = a_r & b_r;
        L_NAND:    lres = ~(a_r & b_r);
        L_OR:      lres = a_r | b_r;
        L_NOR:     lres = ~(a_r | b_r);
        L_XOR:     lres = a_r ^ b_r;
        L_XNOR:    lres = ~(a_r ^ b_r);
        L_NOT_A:   lres = ~a_r;
        L_NOT_B:   lres = ~b_r;
        L_SHR1_A:  lres = a_r >> 1;
        L_SHL1_A:  lres = a_r << 1;
        L_SHR1_B:  lres = b_r >> 1;
        L_SHL1_B:  lres = b_r << 1;
        L_ROL_A_B: begin
          rot   = {a_r, a_r} << amt;
          lres  = rot[2*DATA_WIDTH-1:DATA_WIDTH];
          r_err = (b_r >> SH) != '0;
        end
        L_ROR_A_B: begin
          rot   = {a_r, a_r} >> amt;
          lres  = rot[DATA_WIDTH-1:0];
          r_err = (b_r >> SH) != '0;
        end
        default:   r_err = 1'b1;
      endcase
      r_res = RESULT_WIDTH'(lres);
    end
  end

  alu_mul_pipe #(.DATA_WIDTH(DATA_WIDTH), .RESULT_WIDTH(RESULT_WIDTH)) u_mul (
    .clk(clk), .rst(rst), .ce(ce), .shl(op_r == A_MUL_SHL),
    .a(a_r), .b(b_r), .p(mul_p)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      res <= '0; err <= 1'b0; oflow <= 1'b0; cout <= 1'b0;
      g <= 1'b0; l <= 1'b0; e <= 1'b0;
    end else if (ce) begin
      if (fin_exec) begin
        res <= r_res; err <= r_err; oflow <= r_oflow; cout <= r_cout;
        g <= r_g; l <= r_l; e <= r_e;
      end else if (fin_tmo || fin_mul) begin
        res <= fin_mul ? mul_p : '0;
        err <= fin_tmo; oflow <= 1'b0; cout <= 1'b0;
        g <= 1'b0; l <= 1'b0; e <= 1'b0;
      end
    end
  end
endmodule
